// File: rtl/edge_pkg.sv
// edge_pkg: mode encoding and popcount helper shared by the edge detector files.
package edge_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_t;

   localparam int MAX_CH = 64;

   function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
      popcount = 0;
      for (int i = 0; i < MAX_CH; i++) popcount = popcount + {31'b0, v[i]};
   endfunction

endpackage

// File: rtl/edge_chan.sv
// edge_chan: one channel's synchroniser, optional debounce, edge detect and mode select.
// Debounce filter is compiled in with EDGE_DEBOUNCE_EN.
module edge_chan
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES = 2
`ifdef EDGE_DEBOUNCE_EN
   , parameter int FILTER_CYCLES = 4
`endif
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  din,
   input  mode_t mode,
   output logic  pulse_next
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s, f, prev_q, rise, fall;

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = din;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= f;
      end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
   localparam int CW = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          f_q, f_d;

   // the stable level flips only after FILTER_CYCLES consecutive disagreeing samples
   always_comb begin
      cnt_d = (s == f_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      f_d   = (s != f_q && cnt_q == LAST) ? s : f_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt_q <= '0;
         f_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         f_q   <= f_d;
      end

   assign f = f_q;
`else
   assign f = s;
`endif

   assign rise = f & ~prev_q;
   assign fall = ~f & prev_q;

   assign pulse_next = (mode == MODE_BOTH) ? (rise | fall) :
                       (mode == MODE_RISE) ? rise :
                       (mode == MODE_FALL) ? fall : 1'b0;

endmodule

// File: rtl/edge_detector_multi.sv
// edge_detector_multi: N-channel edge detector with pulses, sticky flags, irq and event counter.
// Per-channel debounce is compiled in with EDGE_DEBOUNCE_EN.
module edge_detector_multi
   import edge_pkg::*;
#(
   parameter int N             = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     din,
   input  logic [2*N-1:0]   mode,
   input  logic [N-1:0]     clr,
   input  logic [N-1:0]     irq_mask,
   input  logic             cnt_clr,
   output logic [N-1:0]     pulse,
   output logic [N-1:0]     sticky,
   output logic             irq,
   output logic [CNT_W-1:0] evt_cnt
);

   if (N < 1 || N > MAX_CH || SYNC_STAGES < 1 || FILTER_CYCLES < 1 || CNT_W < 1) begin : g_bad
      $error("edge_detector_multi: illegal parameter value");
   end

   localparam int SW = CNT_W + 7;
   localparam logic [SW-1:0] SAT = SW'({CNT_W{1'b1}});

   logic [N-1:0]     pn, pulse_q, sticky_q, sticky_d;
   logic             irq_q, irq_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    sum;

   for (genvar i = 0; i < N; i++) begin : g_ch
      edge_chan #(
         .SYNC_STAGES  (SYNC_STAGES)
`ifdef EDGE_DEBOUNCE_EN
         , .FILTER_CYCLES(FILTER_CYCLES)
`endif
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .din        (din[i]),
         .mode       (mode_t'(mode[2*i+:2])),
         .pulse_next (pn[i])
      );
   end

   // a clear in the same cycle as events reloads with that cycle's event count
   always_comb begin
      sticky_d = (sticky_q & ~clr) | pn;
      irq_d    = |(sticky_q & irq_mask);
      sum      = (cnt_clr ? '0 : SW'(cnt_q)) + SW'(popcount(MAX_CH'(pn)));
      cnt_d    = (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pulse_q  <= '0;
         sticky_q <= '0;
         irq_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         pulse_q  <= pn;
         sticky_q <= sticky_d;
         irq_q    <= irq_d;
         cnt_q    <= cnt_d;
      end

   assign pulse   = pulse_q;
   assign sticky  = sticky_q;
   assign irq     = irq_q;
   assign evt_cnt = cnt_q;

endmodule
